// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU phase sequencer.
// Holds the state encodings (SEQ_STATE_FETCH .. SEQ_STATE_TRAP) and the
// state register width used by cpu_sequencer.
package cpu_sequencer_pkg;

    localparam int unsigned SEQ_STATE_WIDTH = 3;
    localparam int unsigned PERF_COUNT_WIDTH = 64;

    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_FETCH     = 3'd0;
    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_DECODE    = 3'd1;
    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_EXECUTE   = 3'd2;
    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_MEM       = 3'd3;
    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_WRITEBACK = 3'd4;
    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_HALTED    = 3'd5;
    localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_TRAP      = 3'd6;

endpackage

// File: rtl/cpu_sequencer_perf_counter.sv
// perf_counter: free-running event counter with synchronous clear.
// Ports:
//   i_Clock  - clock
//   i_Clear  - synchronous clear (priority over increment)
//   i_Incr   - add one this cycle
//   o_Count  - current count, wraps modulo 2^WIDTH
module perf_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_Clock,
    input  logic             i_Clear,
    input  logic             i_Incr,
    output logic [WIDTH-1:0] o_Count
);

    // Counter register
    always_ff @(posedge i_Clock) begin
        if (i_Clear) begin
            o_Count <= '0;
        end else if (i_Incr) begin
            o_Count <= o_Count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle phase sequencer (fetch/decode/execute/mem/wb)
// with halt and illegal-instruction trap handling.
// Optional feature macro: SEQUENCER_PERF_COUNTERS_EN adds o_Cycle_Count and
// o_Retired_Count (64-bit, cleared by i_Reset).
// Ports:
//   i_Clock, i_Reset        - clock, synchronous active-high reset
//   i_Halt                  - stop at next instruction boundary
//   i_Instr_Ready           - instruction memory data valid
//   i_Mem_Ready             - data memory access complete
//   i_Mem_Access, i_Illegal - decode results, sampled in EXECUTE
//   o_Instr_Req, o_Ir_Load  - fetch request / IR latch (Mealy)
//   o_Cu_Enable, o_Mem_Req  - control unit enable / data memory request
//   o_Reg_Commit, o_Pc_Write_Enable, o_Retire - writeback qualifiers
//   o_Halted, o_Trap        - status
// All outputs are forced low while i_Reset is high.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned STATE_WIDTH = SEQ_STATE_WIDTH
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Halt,
    input  logic i_Instr_Ready,
    input  logic i_Mem_Ready,
    input  logic i_Mem_Access,
    input  logic i_Illegal,
    output logic o_Instr_Req,
    output logic o_Ir_Load,
    output logic o_Cu_Enable,
    output logic o_Mem_Req,
    output logic o_Reg_Commit,
    output logic o_Pc_Write_Enable,
    output logic o_Retire,
    output logic o_Halted,
`ifdef SEQUENCER_PERF_COUNTERS_EN
    output logic o_Trap,
    output logic [PERF_COUNT_WIDTH-1:0] o_Cycle_Count,
    output logic [PERF_COUNT_WIDTH-1:0] o_Retired_Count
`else
    output logic o_Trap
`endif
);

    localparam logic [STATE_WIDTH-1:0] ST_FETCH     = STATE_WIDTH'(SEQ_STATE_FETCH);
    localparam logic [STATE_WIDTH-1:0] ST_DECODE    = STATE_WIDTH'(SEQ_STATE_DECODE);
    localparam logic [STATE_WIDTH-1:0] ST_EXECUTE   = STATE_WIDTH'(SEQ_STATE_EXECUTE);
    localparam logic [STATE_WIDTH-1:0] ST_MEM       = STATE_WIDTH'(SEQ_STATE_MEM);
    localparam logic [STATE_WIDTH-1:0] ST_WRITEBACK = STATE_WIDTH'(SEQ_STATE_WRITEBACK);
    localparam logic [STATE_WIDTH-1:0] ST_HALTED    = STATE_WIDTH'(SEQ_STATE_HALTED);
    localparam logic [STATE_WIDTH-1:0] ST_TRAP      = STATE_WIDTH'(SEQ_STATE_TRAP);

    logic [STATE_WIDTH-1:0] state_q;
    logic [STATE_WIDTH-1:0] state_d;

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; TRAP is absorbing, only reset leaves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (i_Instr_Ready) state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (i_Illegal)         state_d = ST_TRAP;
                else if (i_Mem_Access) state_d = ST_MEM;
                else                   state_d = ST_WRITEBACK;
            end
            ST_MEM:       if (i_Mem_Ready) state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = i_Halt ? ST_HALTED : ST_FETCH;
            ST_HALTED:    if (!i_Halt) state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
    end

    // Output decode; Moore except o_Ir_Load, everything gated off in reset
    always_comb begin
        o_Instr_Req       = 1'b0;
        o_Ir_Load         = 1'b0;
        o_Cu_Enable       = 1'b0;
        o_Mem_Req         = 1'b0;
        o_Reg_Commit      = 1'b0;
        o_Pc_Write_Enable = 1'b0;
        o_Retire          = 1'b0;
        o_Halted          = 1'b0;
        o_Trap            = 1'b0;
        if (!i_Reset) begin
            case (state_q)
                ST_FETCH: begin
                    o_Instr_Req = 1'b1;
                    o_Ir_Load   = i_Instr_Ready;
                end
                ST_DECODE, ST_EXECUTE: o_Cu_Enable = 1'b1;
                ST_MEM: begin
                    o_Cu_Enable = 1'b1;
                    o_Mem_Req   = 1'b1;
                end
                ST_WRITEBACK: begin
                    o_Cu_Enable       = 1'b1;
                    o_Reg_Commit      = 1'b1;
                    o_Pc_Write_Enable = 1'b1;
                    o_Retire          = 1'b1;
                end
                ST_HALTED: o_Halted = 1'b1;
                ST_TRAP:   o_Trap   = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQUENCER_PERF_COUNTERS_EN
    // Cycle counter runs every non-reset cycle
    perf_counter #(.WIDTH(PERF_COUNT_WIDTH)) u_cycle_count (
        .i_Clock (i_Clock),
        .i_Clear (i_Reset),
        .i_Incr  (1'b1),
        .o_Count (o_Cycle_Count)
    );

    // Retired-instruction counter
    perf_counter #(.WIDTH(PERF_COUNT_WIDTH)) u_retired_count (
        .i_Clock (i_Clock),
        .i_Clear (i_Reset),
        .i_Incr  (o_Retire),
        .o_Count (o_Retired_Count)
    );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Per-instruction expectations
// (latency, request/commit cycle counts) are queued when stimulus starts and
// compared when the DUT retires the instruction.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic i_Reset, i_Halt, i_Instr_Ready, i_Mem_Ready, i_Mem_Access, i_Illegal;
    logic o_Instr_Req, o_Ir_Load, o_Cu_Enable, o_Mem_Req, o_Reg_Commit;
    logic o_Pc_Write_Enable, o_Retire, o_Halted, o_Trap;
`ifdef SEQUENCER_PERF_COUNTERS_EN
    logic [63:0] o_Cycle_Count, o_Retired_Count;
`endif
    logic [8:0] outs;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int lat;
        int mreq;
        int loads;
        int cu;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign outs = {o_Instr_Req, o_Ir_Load, o_Cu_Enable, o_Mem_Req, o_Reg_Commit,
                   o_Pc_Write_Enable, o_Retire, o_Halted, o_Trap};

    cpu_sequencer dut (
        .i_Clock           (clk),
        .i_Reset           (i_Reset),
        .i_Halt            (i_Halt),
        .i_Instr_Ready     (i_Instr_Ready),
        .i_Mem_Ready       (i_Mem_Ready),
        .i_Mem_Access      (i_Mem_Access),
        .i_Illegal         (i_Illegal),
        .o_Instr_Req       (o_Instr_Req),
        .o_Ir_Load         (o_Ir_Load),
        .o_Cu_Enable       (o_Cu_Enable),
        .o_Mem_Req         (o_Mem_Req),
        .o_Reg_Commit      (o_Reg_Commit),
        .o_Pc_Write_Enable (o_Pc_Write_Enable),
        .o_Retire          (o_Retire),
        .o_Halted          (o_Halted),
`ifdef SEQUENCER_PERF_COUNTERS_EN
        .o_Trap            (o_Trap),
        .o_Cycle_Count     (o_Cycle_Count),
        .o_Retired_Count   (o_Retired_Count)
`else
        .o_Trap            (o_Trap)
`endif
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Two reset cycles; every output must read 0 in both. Leaves reset high.
    task automatic do_reset();
        @(negedge clk);
        i_Reset = 1'b1; i_Halt = 1'b0; i_Instr_Ready = 1'b0;
        i_Mem_Ready = 1'b0; i_Mem_Access = 1'b0; i_Illegal = 1'b0;
        #1 chk_eq("reset_outs_0", 64'(outs), 64'd0);
        @(negedge clk);
        #1 chk_eq("reset_outs_1", 64'(outs), 64'd0);
    endtask

    // One instruction starting in FETCH at the next negedge.
    task automatic do_instr(input int iwait, input bit mem, input int mwait,
                            input bit halt, input bit spur);
        exp_t e, got;
        int c;
        bit done;
        e.lat   = 4 + iwait + (mem ? 1 + mwait : 0);
        e.mreq  = mem ? 1 + mwait : 0;
        e.loads = 1;
        e.cu    = 3 + (mem ? 1 + mwait : 0);
        sb.push_back(e);
        got = '{0, 0, 0, 0};
        done = 1'b0;
        for (c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            i_Reset       = 1'b0;
            i_Illegal     = 1'b0;
            i_Mem_Access  = mem;
            i_Instr_Ready = (c == iwait) || (spur && c > iwait && c <= iwait + 2);
            i_Mem_Ready   = (mem && c == iwait + 3 + mwait) || (spur && c <= iwait + 1);
            i_Halt        = halt && (c >= iwait + 1);
            #1;
            if (c == 0) chk_eq("req_first_cycle", 64'(o_Instr_Req), 64'd1);
            if (o_Retire && o_Instr_Req) chk_eq("retire_with_req", 64'd1, 64'd0);
            if (o_Reg_Commit && !o_Retire) chk_eq("commit_without_retire", 64'd1, 64'd0);
            got.mreq  += int'(o_Mem_Req);
            got.loads += int'(o_Ir_Load);
            got.cu    += int'(o_Cu_Enable);
            if (o_Retire) begin
                got.lat = c + 1;
                done = 1'b1;
            end
        end
        if (!done) chk_eq("retire_timeout", 64'd0, 64'd1);
        e = sb.pop_front();
        chk_eq("latency", 64'(got.lat), 64'(e.lat));
        chk_eq("mem_req_cycles", 64'(got.mreq), 64'(e.mreq));
        chk_eq("ir_load_cycles", 64'(got.loads), 64'(e.loads));
        chk_eq("cu_enable_cycles", 64'(got.cu), 64'(e.cu));
        i_Instr_Ready = 1'b0;
        i_Mem_Ready   = 1'b0;
        if (halt) begin
            @(negedge clk);
            #1 chk_eq("halted_hold", 64'({o_Halted, o_Instr_Req}), 64'b10);
            @(negedge clk);
            i_Halt = 1'b0;
            #1 chk_eq("halted_last", 64'({o_Halted, o_Instr_Req}), 64'b10);
        end
    endtask

    // Memory instruction whose data access never completes; reset lands in MEM.
    task automatic mem_abort();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_Reset = 1'b0; i_Mem_Access = 1'b1; i_Illegal = 1'b0;
            i_Instr_Ready = (c == 0); i_Mem_Ready = 1'b0; i_Halt = 1'b0;
            #1;
            if (c >= 3) chk_eq("mem_wait_req", 64'(o_Mem_Req), 64'd1);
        end
        @(negedge clk);
        i_Reset = 1'b1;
        #1 chk_eq("abort_mem_req_drop", 64'({o_Mem_Req, o_Retire, o_Reg_Commit}), 64'd0);
        @(negedge clk);
        #1 chk_eq("abort_outs", 64'(outs), 64'd0);
    endtask

    // Illegal instruction: TRAP must hold with no commits whatever the inputs do.
    task automatic do_trap(input int iwait);
        for (int c = 0; c <= iwait + 2; c++) begin
            @(negedge clk);
            i_Reset = 1'b0; i_Illegal = 1'b1; i_Mem_Access = 1'b1;
            i_Instr_Ready = (c == iwait); i_Mem_Ready = 1'b0; i_Halt = 1'b0;
            #1;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            i_Illegal = 1'b0; i_Instr_Ready = 1'b1; i_Mem_Ready = 1'b1;
            i_Halt = k[0];
            #1 chk_eq("trap_hold", 64'(outs), 64'd1);
        end
    endtask

    initial begin
        i_Reset = 1'b1; i_Halt = 1'b0; i_Instr_Ready = 1'b0;
        i_Mem_Ready = 1'b0; i_Mem_Access = 1'b0; i_Illegal = 1'b0;

        do_reset();
        do_instr(0, 1'b0, 0, 1'b0, 1'b0);   // ADD, zero wait
        do_instr(0, 1'b1, 3, 1'b0, 1'b0);   // load, 3 wait cycles
        do_instr(2, 1'b0, 0, 1'b0, 1'b1);   // fetch wait + stray readies
        do_instr(1, 1'b1, 0, 1'b0, 1'b1);   // store + stray readies
        do_instr(0, 1'b0, 0, 1'b1, 1'b0);   // halt raised in DECODE
        do_instr(0, 1'b0, 0, 1'b0, 1'b0);   // resumes after halt
        mem_abort();
        do_instr(0, 1'b0, 0, 1'b0, 1'b0);   // fetch restarts after abort
        do_trap(1);
        do_reset();
        do_instr(3, 1'b1, 1, 1'b0, 1'b0);   // fetch restarts after trap

`ifdef SEQUENCER_PERF_COUNTERS_EN
        do_reset();
        for (int n = 0; n < 3; n++) do_instr(0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        i_Instr_Ready = 1'b0;
        #1;
        chk_eq("retired_count", o_Retired_Count, 64'd3);
        chk_eq("cycle_count", o_Cycle_Count, 64'd12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Absolute safety bound on simulation time
    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

endmodule
